// File: rtl/pll_mon_pkg.sv
// Shared definitions for the PLL lock monitor.
//   state_e   : monitor FSM states
//   DEF_*     : default parameter values
//   cnt_width : bits needed to hold a saturating count 0..max_val
package pll_mon_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } state_e;

    localparam int DEF_CNT_W      = 16;
    localparam int DEF_EXP_RATIO  = 8;
    localparam int DEF_TOL        = 1;
    localparam int DEF_LOCK_CNT   = 4;
    localparam int DEF_UNLOCK_CNT = 2;
    localparam int DEF_TIMEOUT    = 64;

    // Width of a counter that must reach max_val (max_val >= 1).
    function automatic int cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/ref_sync_edge.sv
// Two-flop synchronizer for an asynchronous input plus a registered
// rising-edge pulse. The pulse is high for one cycle, three clock edges
// after the input rises.
//   i_clk   : sampling clock
//   i_rst_n : asynchronous active-low reset
//   i_async : asynchronous input
//   o_rise  : one-cycle rising-edge pulse
module ref_sync_edge (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_async,
    output logic o_rise
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    // Synchronizer chain and edge detect.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_prev <= 1'b0;
            o_rise <= 1'b0;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
            r_prev <= r_sync;
            o_rise <= r_sync & ~r_prev;
        end
    end

endmodule

// File: rtl/pll_lock_monitor.sv
// Digital PLL lock detector. Measures CLK cycles per REF period and
// declares lock after LOCK_CNT consecutive in-tolerance periods; drops
// lock after UNLOCK_CNT consecutive bad periods (measured or timeout).
// Optional feature macro: PLL_LOCK_MON_STATS_EN adds lock_loss_cnt.
//   CLK           : PLL output clock
//   reset         : asynchronous active-low reset
//   en            : synchronous enable, 0 forces IDLE
//   REF           : asynchronous reference clock
//   locked        : lock status
//   ref_lost      : no REF rise within TIMEOUT cycles
//   meas_valid    : one-cycle pulse with each new meas_count
//   meas_count    : last measured period in CLK cycles
//   lock_loss_cnt : (macro only) saturating count of lock losses
module pll_lock_monitor
    import pll_mon_pkg::*;
#(
    parameter int CNT_W      = DEF_CNT_W,
    parameter int EXP_RATIO  = DEF_EXP_RATIO,
    parameter int TOL        = DEF_TOL,
    parameter int LOCK_CNT   = DEF_LOCK_CNT,
    parameter int UNLOCK_CNT = DEF_UNLOCK_CNT,
    parameter int TIMEOUT    = DEF_TIMEOUT
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic             en,
    input  logic             REF,
    output logic             locked,
    output logic             ref_lost,
    output logic             meas_valid,
    output logic [CNT_W-1:0] meas_count
`ifdef PLL_LOCK_MON_STATS_EN
    ,
    output logic [7:0]       lock_loss_cnt
`endif
);

    localparam int GW = cnt_width(LOCK_CNT);
    localparam int BW = cnt_width(UNLOCK_CNT);
    localparam logic [GW-1:0]    LOCK_MAX   = GW'(LOCK_CNT);
    localparam logic [BW-1:0]    UNLOCK_MAX = BW'(UNLOCK_CNT);
    // Lower tolerance bound clamps at zero so the compare stays unsigned.
    localparam logic [CNT_W-1:0] LO_B = CNT_W'((EXP_RATIO > TOL) ? (EXP_RATIO - TOL) : 0);
    localparam logic [CNT_W-1:0] HI_B = CNT_W'(EXP_RATIO + TOL);
    localparam logic [CNT_W-1:0] TO_B = CNT_W'(TIMEOUT);

    state_e           r_state;
    logic [CNT_W-1:0] r_pcnt;
    logic [GW-1:0]    r_good;
    logic [BW-1:0]    r_bad;
    logic             r_armed;

    logic             w_rise;
    logic             w_active;
    logic             w_in_tol;
    logic             w_meas;
    logic             w_tmo;
    logic             w_win_good;
    logic             w_win_bad;
    logic             w_lock;
    logic             w_unlock;
    logic [GW-1:0]    w_good_nxt;
    logic [BW-1:0]    w_bad_nxt;

    ref_sync_edge u_ref_sync (
        .i_clk   (CLK),
        .i_rst_n (reset),
        .i_async (REF),
        .o_rise  (w_rise)
    );

    // Window classification and next good/bad streak counts.
    always_comb begin
        w_active   = en && (r_state != IDLE);
        w_in_tol   = (r_pcnt >= LO_B) && (r_pcnt <= HI_B);
        w_meas     = w_active && w_rise && r_armed;
        // A timeout fires once: ref_lost blocks repeats while pcnt holds.
        w_tmo      = w_active && !w_rise && (r_pcnt == TO_B) && !ref_lost;
        w_win_good = w_meas && w_in_tol;
        w_win_bad  = (w_meas && !w_in_tol) || w_tmo;
        w_good_nxt = r_good;
        w_bad_nxt  = r_bad;
        if (w_win_good) begin
            w_good_nxt = (r_good == LOCK_MAX) ? r_good : r_good + GW'(1);
            w_bad_nxt  = '0;
        end else if (w_win_bad) begin
            w_bad_nxt  = (r_bad == UNLOCK_MAX) ? r_bad : r_bad + BW'(1);
            w_good_nxt = '0;
        end else begin
            w_good_nxt = r_good;
        end
        w_lock   = (r_state == ACQUIRE) && w_win_good && (w_good_nxt == LOCK_MAX);
        w_unlock = (r_state == LOCKED) && w_win_bad && (w_bad_nxt == UNLOCK_MAX);
    end

    // Monitor FSM, period counter, arming and registered outputs.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_pcnt     <= '0;
            r_good     <= '0;
            r_bad      <= '0;
            r_armed    <= 1'b0;
            locked     <= 1'b0;
            ref_lost   <= 1'b0;
            meas_valid <= 1'b0;
            meas_count <= '0;
        end else if (!en) begin
            // meas_count deliberately holds its last value.
            r_state    <= IDLE;
            r_pcnt     <= '0;
            r_good     <= '0;
            r_bad      <= '0;
            r_armed    <= 1'b0;
            locked     <= 1'b0;
            ref_lost   <= 1'b0;
            meas_valid <= 1'b0;
        end else begin
            meas_valid <= w_meas;
            if (w_meas) begin
                meas_count <= r_pcnt;
            end
            case (r_state)
                IDLE: begin
                    r_state  <= ACQUIRE;
                    r_pcnt   <= '0;
                    r_good   <= '0;
                    r_bad    <= '0;
                    r_armed  <= 1'b0;
                    locked   <= 1'b0;
                    ref_lost <= 1'b0;
                end
                ACQUIRE, LOCKED: begin
                    if (w_rise) begin
                        r_pcnt <= CNT_W'(1);
                    end else if (r_pcnt != TO_B) begin
                        r_pcnt <= r_pcnt + CNT_W'(1);
                    end
                    // The edge wins over a coincident timeout.
                    if (w_rise) begin
                        ref_lost <= 1'b0;
                        r_armed  <= 1'b1;
                    end else if (w_tmo) begin
                        ref_lost <= 1'b1;
                        r_armed  <= 1'b0;
                    end
                    r_good <= w_good_nxt;
                    r_bad  <= w_bad_nxt;
                    if (w_lock) begin
                        r_state <= LOCKED;
                        locked  <= 1'b1;
                    end else if (w_unlock) begin
                        // Re-entering ACQUIRE needs a fresh arming edge.
                        r_state <= ACQUIRE;
                        locked  <= 1'b0;
                        r_good  <= '0;
                        r_armed <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    locked  <= 1'b0;
                end
            endcase
        end
    end

`ifdef PLL_LOCK_MON_STATS_EN
    // Lock-loss statistics; survives en=0, cleared only by reset.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            lock_loss_cnt <= 8'd0;
        end else if (w_unlock && (lock_loss_cnt != 8'hFF)) begin
            lock_loss_cnt <= lock_loss_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: doc/pll_lock_monitor.md
Name: pll_lock_monitor

Overview:
- Digital lock detector for the on-chip PLL.
- Runs on the PLL output clock CLK. Samples the asynchronous reference REF and measures the number of CLK cycles per REF period.
- Declares lock after LOCK_CNT consecutive in-tolerance periods, and drops lock after UNLOCK_CNT consecutive bad periods.
- Sits beside the PLL. Its outputs gate core release and feed status/debug.

Parameters:
- CNT_W, 16: width of period counter and meas_count.
- EXP_RATIO, 8: expected CLK cycles per REF period.
- TOL, 1: allowed deviation; good iff |meas − EXP_RATIO| ≤ TOL.
- LOCK_CNT, 4: consecutive good periods needed to assert locked (≥1).
- UNLOCK_CNT, 2: consecutive bad periods needed to deassert locked (≥1).
- TIMEOUT, 64: CLK cycles without a REF rise before ref_lost. Must satisfy TIMEOUT > EXP_RATIO+TOL and TIMEOUT < 2^CNT_W.

Ports:
- CLK  in  1  PLL output clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- en  in  1  synchronous enable; 0 forces IDLE.
- REF  in  1  asynchronous reference clock.
- locked  out  1  lock status.
- ref_lost  out  1  no REF rise within TIMEOUT cycles.
- meas_valid  out  1  one-cycle pulse when a new meas_count is written.
- meas_count  out  CNT_W  last measured period in CLK cycles.

Behaviour:
- Reset (reset=0, async): all outputs 0, state IDLE, all counters 0, sync flops 0.
- REF path: 2-flop synchronizer plus rising-edge detect. ref_rise is high one cycle, 3 CLK edges after the REF rise.
- Period counter pcnt:
  - set to 1 on ref_rise;
  - otherwise increments each cycle;
  - saturates at TIMEOUT.
- Flag `armed` is set by the first ref_rise after entering ACQUIRE or after a timeout. The first ref_rise only arms; it produces no measurement.
- Measurement, on ref_rise while armed:
  - meas_count←pcnt and meas_valid=1 on the next cycle;
  - window classified good or bad;
  - good_cnt/bad_cnt updated on the same edge.
  - Good: good_cnt++ (saturating at LOCK_CNT), bad_cnt←0.
  - Bad: bad_cnt++ (saturating at UNLOCK_CNT), good_cnt←0.
- Timeout, when pcnt==TIMEOUT and no ref_rise:
  - ref_lost←1, armed←0, counted once as a bad window;
  - pcnt holds, no meas_valid.
  - ref_lost clears on the next ref_rise, which re-arms.
- Simultaneous ref_rise and pcnt==TIMEOUT: the edge wins. A measurement of TIMEOUT is taken (bad), and ref_lost is not set.
- FSM:
  - IDLE: locked=0, counters cleared. en=1 → ACQUIRE.
  - ACQUIRE: locked=0. A good window making good_cnt reach LOCK_CNT → LOCKED; locked=1 on the same edge meas_valid rises.
  - LOCKED: locked=1. A bad window (measured or timeout) making bad_cnt reach UNLOCK_CNT → ACQUIRE, locked←0, good_cnt←0.
  - Any state with en=0 → IDLE next edge: locked, ref_lost, counters, armed cleared; meas_count holds.
- Arithmetic: the comparison is done unsigned as EXP_RATIO−TOL ≤ pcnt ≤ EXP_RATIO+TOL, with the lower bound clamped at 0.

Optional Feature:
- Macro: PLL_LOCK_MON_STATS_EN.
- Defined: adds output lock_loss_cnt [7:0]. It increments, saturating at 255, on each LOCKED→ACQUIRE transition. It is cleared only by reset, not by en=0.
- Undefined: port and logic absent. All other behaviour is identical.

Decomposition:
- Package pll_mon_pkg holds:
  - state enum {IDLE, ACQUIRE, LOCKED};
  - default constants for CNT_W, EXP_RATIO, TOL;
  - a localparam helper for the counter width of LOCK_CNT/UNLOCK_CNT.
- One sub-module, ref_sync_edge: 2-flop synchronizer plus rising-edge pulse, async active-low reset.

Test Plan:
- REF period = exactly 8 CLK, en=1 → meas_count=8 on each meas_valid. locked rises with the 4th meas_valid, i.e. after 5 REF rises including the arming edge.
- While locked, one REF period of 10 CLK then back to 8 → bad_cnt=1, locked stays 1. Two consecutive 10-cycle periods → locked=0 on the 2nd meas_valid, state ACQUIRE.
- Periods of 7 and 9 CLK (edge of TOL=1) → counted good, lock achieved. Periods of 6 → never locks.
- REF stopped while locked → ref_lost=1 at pcnt==64 and bad_cnt=1. A second timeout is impossible without an edge, so locked stays 1. On restart, ref_lost clears on the first ref_rise with no meas_valid; measurement resumes on the following edge.
- en dropped mid-acquire (good_cnt=2) → IDLE next cycle, locked=0. Re-enable needs an arming edge plus 4 fresh good periods.
- reset asserted asynchronously mid-LOCKED (between CLK edges) → all outputs 0 immediately. With PLL_LOCK_MON_STATS_EN, lock_loss_cnt=0; after three lock/unlock cycles, lock_loss_cnt=3.
